// File: rtl/async_xing_src_arbiter.sv
// Round-robin source side of a two-phase toggle crossing: accepts one requester per toggle, holds data until the synchronized ack returns.
// Latency: accept-to-launch 1 cycle; ready stays low while a toggle is outstanding, with a sticky watchdog flag on stalled acks.
module async_xing_src_arbiter #(
    parameter int N           = 4,
    parameter int W           = 32,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT     = 255
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N-1:0]                  io_req_valid,
    input  logic [N*W-1:0]                io_req_data,
    output logic [N-1:0]                  io_req_ready,
    output logic                          io_xing_req,
    output logic [W-1:0]                  io_xing_data,
    input  logic                          io_xing_ack,
    output logic                          io_busy,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] io_grant_id,
    output logic                          io_err
);
    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          last_q, last_d;
    logic [IW-1:0]          grant_id_q, grant_id_d;
    logic                   xreq_q, xreq_d;
    logic [W-1:0]           xdat_q, xdat_d;
    logic [WDW-1:0]         wdog_q, wdog_d;
    logic                   err_q, err_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;

    logic                   ack_sync;
    logic                   found;
    logic [IW-1:0]          grant;
    logic [N-1:0]           ready_c;
    int                     cand;

    assign ack_sync   = ack_sync_q[SYNC_STAGES-1];
    assign ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], io_xing_ack};

    // Scan upward from the requester after the last winner, wrapping at N.
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(last_q) + 1 + k;
            if (cand >= N) cand = cand - N;
            if (!found && io_req_valid[cand[IW-1:0]]) begin
                found = 1'b1;
                grant = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        grant_id_d = grant_id_q;
        xreq_d     = xreq_q;
        xdat_d     = xdat_q;
        wdog_d     = wdog_q;
        err_d      = err_q;
        ready_c    = '0;
        if (state_q == ST_IDLE) begin
            if (found) begin
                ready_c    = {{(N-1){1'b0}}, 1'b1} << grant;
                xdat_d     = io_req_data[grant*W +: W];
                xreq_d     = ~xreq_q;
                last_d     = grant;
                grant_id_d = grant;
                wdog_d     = '0;
                state_d    = ST_WAIT;
            end
        end else begin
            // Watchdog keeps counting even on the ack cycle so a coincident timeout still flags.
            if (wdog_q != WDW'(TIMEOUT)) wdog_d = wdog_q + 1'b1;
            if (wdog_d == WDW'(TIMEOUT)) err_d = 1'b1;
            if (ack_sync == xreq_q) state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            last_q     <= IW'(N - 1);
            grant_id_q <= '0;
            xreq_q     <= 1'b0;
            xdat_q     <= '0;
            wdog_q     <= '0;
            err_q      <= 1'b0;
            ack_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_id_q <= grant_id_d;
            xreq_q     <= xreq_d;
            xdat_q     <= xdat_d;
            wdog_q     <= wdog_d;
            err_q      <= err_d;
            ack_sync_q <= ack_sync_d;
        end
    end

    assign io_req_ready = reset ? '0 : ready_c;
    assign io_xing_req  = xreq_q;
    assign io_xing_data = xdat_q;
    assign io_busy      = (state_q == ST_WAIT);
    assign io_grant_id  = grant_id_q;
    assign io_err       = err_q;
endmodule

// File: tb/tb_async_xing_src_arbiter.sv
// Directed bench for async_xing_src_arbiter with loopback and manually driven acks.
module tb_async_xing_src_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           xing_req;
    logic [W-1:0]   xing_data;
    logic           xing_ack;
    logic           busy;
    logic [1:0]     grant_id;
    logic           err;

    logic           loop_en;
    logic           ack_man;
    logic           exp_req;
    logic [W-1:0]   pay [0:3];
    int             seq [0:5];
    int             tests = 0;
    int             fails = 0;

    assign xing_ack = loop_en ? xing_req : ack_man;

    always #5 clock = ~clock;

    async_xing_src_arbiter #(.N(N), .W(W), .SYNC_STAGES(3), .TIMEOUT(255)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_req_valid (req_valid),
        .io_req_data  (req_data),
        .io_req_ready (req_ready),
        .io_xing_req  (xing_req),
        .io_xing_data (xing_data),
        .io_xing_ack  (xing_ack),
        .io_busy      (busy),
        .io_grant_id  (grant_id),
        .io_err       (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        loop_en   = 1'b1;
        ack_man   = 1'b0;
        req_valid = '0;
        exp_req   = 1'b0;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_xreq", xing_req, 0);
        chk("rst_xdata", xing_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_err", err, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // One loopback transfer: accept g, launch, four WAIT cycles, back to IDLE.
    task automatic xfer(input int g);
        #1;
        chk("acc_ready", req_ready, 64'd1 << g);
        tick();
        exp_req = ~exp_req;
        chk("launch_grant", grant_id, g);
        chk("launch_data", xing_data, pay[g]);
        chk("launch_req", xing_req, exp_req);
        chk("launch_busy", busy, 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("wait_ready", req_ready, 0);
            chk("wait_busy", busy, 1);
        end
        tick();
        chk("idle_busy", busy, 0);
    endtask

    // Delayed-ack transfer: ack returns 10 cycles after the toggle.
    task automatic slow_wait(input int g);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("slow_busy", busy, 1);
            chk("slow_ready", req_ready, 0);
            chk("slow_data", xing_data, pay[g]);
        end
        ack_man = ~ack_man;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("sync_busy", busy, 1);
            chk("sync_data", xing_data, pay[g]);
        end
        tick();
        chk("slow_idle", busy, 0);
    endtask

    initial begin
        pay[0] = 32'h1234_5678;
        pay[1] = 32'h89AB_CDEF;
        pay[2] = 32'h0BAD_F00D;
        pay[3] = 32'hCAFE_BABE;
        req_data = {pay[3], pay[2], pay[1], pay[0]};
        seq[0] = 0; seq[1] = 1; seq[2] = 2; seq[3] = 3; seq[4] = 0; seq[5] = 1;

        // Single requester with loopback
        do_reset();
        req_valid = 4'b0001;
        xfer(0);
        #1;
        chk("t1_reassert", req_ready, 4'b0001);
        req_valid = '0;

        // All requesters, rotating grants
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) xfer(seq[i]);

        // Sparse requesters after last = 1
        do_reset();
        req_valid = 4'b0010;
        xfer(1);
        req_valid = 4'b1010;
        xfer(3);
        xfer(1);
        xfer(3);
        req_valid = '0;

        // Watchdog timeout with ack stuck low
        do_reset();
        loop_en   = 1'b0;
        req_valid = 4'b0001;
        #1;
        chk("to_acc", req_ready, 4'b0001);
        tick();
        chk("to_req", xing_req, 1);
        for (int k = 1; k <= 260; k++) begin
            tick();
            chk("to_err", err, (k >= 255) ? 1 : 0);
            chk("to_ready", req_ready, 0);
            chk("to_busy", busy, 1);
        end
        ack_man = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("to_sync_busy", busy, 1);
        end
        tick();
        chk("to_idle_busy", busy, 0);
        chk("to_err_sticky", err, 1);
        chk("to_idle_ready", req_ready, 4'b0001);
        req_valid = '0;

        // Reset in the middle of a WAIT
        do_reset();
        req_valid = 4'b0100;
        #1;
        chk("mr_acc", req_ready, 4'b0100);
        tick();
        chk("mr_req", xing_req, 1);
        chk("mr_grant", grant_id, 2);
        #2;
        reset     = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("mr_xreq", xing_req, 0);
        chk("mr_xdata", xing_data, 0);
        chk("mr_busy", busy, 0);
        chk("mr_grant0", grant_id, 0);
        chk("mr_ready", req_ready, 0);
        chk("mr_err", err, 0);
        tick();
        reset   = 1'b0;
        exp_req = 1'b0;
        xfer(0);
        req_valid = '0;

        // Delayed ack, two back-to-back transfers
        do_reset();
        loop_en   = 1'b0;
        req_valid = 4'b0011;
        #1;
        chk("sl_acc0", req_ready, 4'b0001);
        tick();
        chk("sl_req1", xing_req, 1);
        chk("sl_data0", xing_data, pay[0]);
        slow_wait(0);
        chk("sl_acc1", req_ready, 4'b0010);
        tick();
        chk("sl_req0", xing_req, 0);
        chk("sl_data1", xing_data, pay[1]);
        chk("sl_grant1", grant_id, 1);
        slow_wait(1);
        chk("sl_err", err, 0);
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
